// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: IF-stage PC register with prioritised redirect selection,
// stall-time redirect buffering with replay, and a multi-cycle fetch flush.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect -> TRAP_PC).
module pc_redirect_unit #(
    parameter int unsigned       WIDTH        = 32,
    parameter int unsigned       NUM_SRC      = 3,
    parameter logic [WIDTH-1:0]  RESET_PC     = '0,
    parameter int unsigned       FLUSH_CYCLES = 1,
    parameter logic [WIDTH-1:0]  TRAP_PC      = 'h80
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic [NUM_SRC-1:0]         redirect_valid,
    input  logic [NUM_SRC*WIDTH-1:0]   redirect_addr,
    output logic [WIDTH-1:0]           pc,
    output logic [WIDTH-1:0]           pc_plus_4,
    output logic                       flush,
    output logic                       redirect_taken,
    output logic                       pending,
    output logic                       misalign_err
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_CYCLES);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             pending_q, pending_d;
    logic             taken_q, taken_d;
    logic             mis_q, mis_d;
    logic             flush_q;
    logic [3:0]       cnt_q, cnt_d;

    logic             any_valid;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] apply_raw;
    logic             misaligned;

    assign pc_plus_4 = pc_q + WIDTH'(4);

    // Priority select: later (higher-index) valid sources override earlier ones.
    always_comb begin
        any_valid = 1'b0;
        sel_addr  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (redirect_valid[i]) begin
                any_valid = 1'b1;
                sel_addr  = redirect_addr[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: apply fresh or buffered redirect, step sequentially, or buffer under stall.
    // The buffer keeps the raw target so a misaligned address is still detectable at replay.
    always_comb begin
        pc_d       = pc_q;
        buf_d      = buf_q;
        pending_d  = pending_q;
        taken_d    = 1'b0;
        mis_d      = 1'b0;
        cnt_d      = cnt_q;
        apply_raw  = any_valid ? sel_addr : buf_q;
        misaligned = (apply_raw[1:0] != 2'b00);
        if (!stall) begin
            if (any_valid || pending_q) begin
                if (TRAP_EN && misaligned) begin
                    pc_d  = TRAP_PC;
                    mis_d = 1'b1;
                end else begin
                    pc_d = {apply_raw[WIDTH-1:2], 2'b00};
                end
                pending_d = 1'b0;
                taken_d   = 1'b1;
                cnt_d     = FLUSH_CNT;
            end else begin
                pc_d = pc_plus_4;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        end else if (any_valid) begin
            buf_d     = sel_addr;
            pending_d = 1'b1;
        end
    end

    // State registers; asynchronous reset discards any buffered redirect and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            buf_q     <= '0;
            pending_q <= 1'b0;
            taken_q   <= 1'b0;
            mis_q     <= 1'b0;
            cnt_q     <= '0;
            flush_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            buf_q     <= buf_d;
            pending_q <= pending_d;
            taken_q   <= taken_d;
            mis_q     <= mis_d;
            cnt_q     <= cnt_d;
            flush_q   <= (cnt_d != 4'd0);
        end
    end

    assign pc             = pc_q;
    assign flush          = flush_q;
    assign redirect_taken = taken_q;
    assign pending        = pending_q;
    assign misalign_err   = mis_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit (FLUSH_CYCLES=3); driver queues expected
// post-edge state, a negedge monitor pops and compares.
module tb_pc_redirect_unit;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [2:0]  redirect_valid;
    logic [95:0] redirect_addr;
    logic [31:0] pc, pc_plus_4;
    logic        flush, redirect_taken, pending, misalign_err;

    pc_redirect_unit #(
        .WIDTH(32),
        .NUM_SRC(3),
        .RESET_PC(32'h0),
        .FLUSH_CYCLES(3),
        .TRAP_PC(32'h80)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .pc(pc),
        .pc_plus_4(pc_plus_4),
        .flush(flush),
        .redirect_taken(redirect_taken),
        .pending(pending),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        fl;
        logic        tk;
        logic        pd;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_id = 0;

    task automatic check(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, id, got, want);
        end
    endtask

    // Monitor: every negedge the DUT presents a new state; compare with oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc",             e.id, pc,                    e.pc);
            check("pc_plus_4",      e.id, pc_plus_4,             e.pc + 32'd4);
            check("flush",          e.id, {31'd0, flush},         {31'd0, e.fl});
            check("redirect_taken", e.id, {31'd0, redirect_taken},{31'd0, e.tk});
            check("pending",        e.id, {31'd0, pending},       {31'd0, e.pd});
            check("misalign_err",   e.id, {31'd0, misalign_err},  {31'd0, e.mis});
        end
    end

    task automatic expect_state(input logic [31:0] epc, input logic efl, input logic etk,
                                input logic epd, input logic emis);
        exp_t e;
        step_id++;
        e.id = step_id; e.pc = epc; e.fl = efl; e.tk = etk; e.pd = epd; e.mis = emis;
        exp_q.push_back(e);
    endtask

    // One clock edge with given inputs; expectation describes state after the edge.
    task automatic step(input logic st, input logic [2:0] v,
                        input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                        input logic [31:0] epc, input logic efl, input logic etk,
                        input logic epd, input logic emis);
        expect_state(epc, efl, etk, epd, emis);
        stall          = st;
        redirect_valid = v;
        redirect_addr  = {a2, a1, a0};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] epc, input logic efl);
        step(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, epc, efl, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = '0;
        redirect_addr  = '0;
        expect_state(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // free-running sequential fetch
        idle(32'h4, 1'b0);
        idle(32'h8, 1'b0);
        idle(32'hC, 1'b0);
        idle(32'h10, 1'b0);

        // simultaneous sources 0 and 2: source 2 wins; flush for exactly 3 cycles
        step(1'b0, 3'b101, 32'h100, 32'h0, 32'h300, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(32'h304, 1'b1);
        idle(32'h308, 1'b1);
        idle(32'h30C, 1'b0);
        idle(32'h310, 1'b0);

        // redirect during stall is buffered, replayed on release
        step(1'b1, 3'b010, 32'h0, 32'h40, 32'h0, 32'h310, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h310, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h310, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h310, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(32'h44, 1'b1);
        idle(32'h48, 1'b1);
        idle(32'h4C, 1'b0);

        // fresh redirect at release supersedes buffered one
        step(1'b1, 3'b010, 32'h0, 32'h40, 32'h0, 32'h4C, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'b001, 32'h80, 32'h0, 32'h0, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(32'h84, 1'b1);

        // newer stalled redirect overwrites buffer; flush counter holds under stall
        step(1'b1, 3'b100, 32'h0, 32'h0, 32'h1234, 32'h84, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b001, 32'h2000, 32'h0, 32'h0, 32'h84, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(32'h2004, 1'b1);

        // redirect while flushing reloads counter; stall 2 cycles; falls after 3 unstalled edges
        step(1'b0, 3'b100, 32'h0, 32'h0, 32'h20, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(32'h24, 1'b1);
        idle(32'h28, 1'b1);
        idle(32'h2C, 1'b0);

        // wrap from 0xFFFFFFFC to 0
        step(1'b0, 3'b010, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(32'h0, 1'b1);
        idle(32'h4, 1'b1);
        idle(32'h8, 1'b0);

        // misaligned redirect: trap or silently aligned
        step(1'b0, 3'b001, 32'h102, 32'h0, 32'h0, TRAP ? 32'h80 : 32'h100, 1'b1, 1'b1, 1'b0, TRAP);
        idle(TRAP ? 32'h84 : 32'h104, 1'b1);
        step(1'b1, 3'b100, 32'h0, 32'h0, 32'h207, TRAP ? 32'h84 : 32'h104, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, TRAP ? 32'h80 : 32'h204, 1'b1, 1'b1, 1'b0, TRAP);
        idle(TRAP ? 32'h84 : 32'h208, 1'b1);

        // reset mid-stall and mid-flush discards everything
        step(1'b1, 3'b001, 32'h500, 32'h0, 32'h0, TRAP ? 32'h84 : 32'h208, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = '0;
        expect_state(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(32'h4, 1'b0);
        idle(32'h8, 1'b0);

        // drain scoreboard with a bounded wait
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
